// File: rtl/otter_intc_pkg.sv
// Shared types and register map for the OTTER multi-channel interrupt controller.
package otter_intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } intc_state_e;

    localparam int ID_W     = 6;
    localparam int LATCNT_W = 16;

    localparam logic [4:0] OFF_PENDING = 5'h00;
    localparam logic [4:0] OFF_ENABLE  = 5'h04;
    localparam logic [4:0] OFF_MODE    = 5'h08;
    localparam logic [4:0] OFF_ACTIVE  = 5'h0C;
    localparam logic [4:0] OFF_EOI     = 5'h10;
    localparam logic [4:0] OFF_LATCNT  = 5'h14;

    // The block owns a 32-byte window; only the upper address bits select it.
    function automatic logic addr_hits(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:5] == base[31:5];
    endfunction

endpackage

// File: rtl/otter_intr_ctrl_if.sv
// MMIO bus between the OTTER CPU (master) and the interrupt controller (slave).
interface otter_intr_ctrl_if;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] RD_DATA;

    modport master (
        output IOBUS_ADDR,
        output IOBUS_OUT,
        output IOBUS_WR,
        input  RD_DATA
    );

    modport slave (
        input  IOBUS_ADDR,
        input  IOBUS_OUT,
        input  IOBUS_WR,
        output RD_DATA
    );
endinterface

// File: rtl/otter_intc_sync.sv
// Per-line input synchroniser with rising-edge detect. level_o/rise_o describe the value
// about to enter the last stage, so a register fed from them tracks the synchronised line.
module otter_intc_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign level_o = sync_q[STAGES-2];
    assign rise_o  = sync_q[STAGES-2] & ~sync_q[STAGES-1];

endmodule

// File: rtl/otter_intr_ctrl.sv
// OTTER interrupt controller: N_CH synchronised requests, enable/mode masks, lowest-index
// priority, single in-service tracking with EOI. Define INTC_LATCNT_EN for the ack-latency counter.
module otter_intr_ctrl
    import otter_intc_pkg::*;
#(
    parameter int          N_CH        = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_CH-1:0]  IRQ_IN,
    otter_intr_ctrl_if.slave bus,
    input  logic             INT_ACK,
    output logic             INTR,
    output logic [ID_W-1:0]  ACTIVE_ID
);

    logic [N_CH-1:0] irq_level;
    logic [N_CH-1:0] irq_rise;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_sync
            otter_intc_sync #(.STAGES(SYNC_STAGES)) u_sync (
                .clk     (CLK),
                .rst     (RESET),
                .d_i     (IRQ_IN[gi]),
                .level_o (irq_level[gi]),
                .rise_o  (irq_rise[gi])
            );
        end
    endgenerate

    logic            hit;
    logic [4:0]      offset;
    logic            wr_en;
    logic            wr_pending, wr_enable, wr_mode, wr_eoi;
    logic [N_CH-1:0] wdata;
    logic            unused_wdata;

    assign hit          = addr_hits(bus.IOBUS_ADDR, BASE_ADDR);
    assign offset       = bus.IOBUS_ADDR[4:0];
    assign wr_en        = bus.IOBUS_WR & hit;
    assign wr_pending   = wr_en && (offset == OFF_PENDING);
    assign wr_enable    = wr_en && (offset == OFF_ENABLE);
    assign wr_mode      = wr_en && (offset == OFF_MODE);
    assign wr_eoi       = wr_en && (offset == OFF_EOI);
    assign wdata        = bus.IOBUS_OUT[N_CH-1:0];
    assign unused_wdata = ^bus.IOBUS_OUT;

    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] enable_q, enable_d;
    logic [N_CH-1:0] mode_q, mode_d;
    logic [N_CH-1:0] grant_q, grant_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] active_q, active_d;
    intc_state_e     state_q, state_d;

    logic [N_CH-1:0] w1c;
    logic [N_CH-1:0] ack_clr;

    assign w1c      = wr_pending ? wdata : '0;
    assign enable_d = wr_enable ? wdata : enable_q;
    assign mode_d   = wr_mode ? wdata : mode_q;

    // Edge channels: a new edge beats any clear landing in the same cycle.
    // Level channels simply follow the synchronised line.
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_pend
            assign pending_d[gi] = mode_q[gi]
                ? (irq_rise[gi] | (pending_q[gi] & ~(w1c[gi] | ack_clr[gi])))
                : irq_level[gi];
        end
    endgenerate

    logic [N_CH-1:0] req;
    logic            win_valid;
    logic [N_CH-1:0] win_oh;
    logic [ID_W-1:0] win_id;

    assign req       = pending_q & enable_q;
    assign win_valid = |req;

    always_comb begin
        win_oh = '0;
        win_id = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_id    = ID_W'(i);
            end
        end
    end

    logic grant_live;
    assign grant_live = |(grant_q & pending_q & enable_q);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        id_d     = id_q;
        active_d = active_q;
        ack_clr  = '0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = ASSERT;
                    grant_d = win_oh;
                    id_d    = win_id;
                end
            end
            ASSERT: begin
                // A request withdrawn before the CPU takes it must not enter service.
                if (!grant_live) begin
                    state_d = IDLE;
                end else if (INT_ACK) begin
                    state_d  = SERVICE;
                    active_d = id_q + ID_W'(1);
                    ack_clr  = grant_q & mode_q;
                end
            end
            SERVICE: begin
                if (wr_eoi) begin
                    state_d  = IDLE;
                    active_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            grant_q   <= '0;
            id_q      <= '0;
            active_q  <= '0;
            state_q   <= IDLE;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            active_q  <= active_d;
            state_q   <= state_d;
        end
    end

    assign INTR      = (state_q == ASSERT) && grant_live;
    assign ACTIVE_ID = active_q;

    logic [31:0] latcnt_rd;

`ifdef INTC_LATCNT_EN
    logic [LATCNT_W-1:0] latcnt_q, latcnt_d;

    always_comb begin
        latcnt_d = latcnt_q;
        if (state_q != ASSERT && state_d == ASSERT) begin
            latcnt_d = '0;
        end else if (state_q == ASSERT && !INT_ACK && latcnt_q != '1) begin
            latcnt_d = latcnt_q + LATCNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            latcnt_q <= '0;
        end else begin
            latcnt_q <= latcnt_d;
        end
    end

    assign latcnt_rd = 32'(latcnt_q);
`else
    assign latcnt_rd = '0;
`endif

    logic [31:0] rd_data;

    always_comb begin
        rd_data = '0;
        if (hit) begin
            case (offset)
                OFF_PENDING: rd_data = 32'(pending_q);
                OFF_ENABLE:  rd_data = 32'(enable_q);
                OFF_MODE:    rd_data = 32'(mode_q);
                OFF_ACTIVE:  rd_data = 32'(active_q);
                OFF_LATCNT:  rd_data = latcnt_rd;
                default:     rd_data = '0;
            endcase
        end
    end

    assign bus.RD_DATA = rd_data;

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Scoreboard bench for otter_intr_ctrl: stimulus queues expectations, a negedge monitor checks them.
module tb_otter_intr_ctrl;
    import otter_intc_pkg::*;

    localparam int          N_CH = 8;
    localparam logic [31:0] BASE = 32'h1100_0100;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] irq = '0;
    logic            int_ack = 1'b0;
    logic            intr;
    logic [5:0]      active_id;

    otter_intr_ctrl_if bus();

    otter_intr_ctrl #(
        .N_CH        (N_CH),
        .BASE_ADDR   (BASE),
        .SYNC_STAGES (2)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .IRQ_IN    (irq),
        .bus       (bus),
        .INT_ACK   (int_ack),
        .INTR      (intr),
        .ACTIVE_ID (active_id)
    );

    always #5 clk = ~clk;

    typedef enum int {P_RD, P_INTR, P_ACT} probe_e;
    typedef struct {
        probe_e      sel;
        logic [31:0] exp;
        string       name;
    } probe_t;

    probe_t probe_q[$];
    int     exp_id_q[$];
    int     checks = 0;
    int     errors = 0;

    // Monitor: consumes queued probes and checks every service entry against the expected id order.
    logic [5:0] prev_active = '0;
    always @(negedge clk) begin : monitor
        probe_t      p;
        logic [31:0] act;
        int          want;
        while (probe_q.size() > 0) begin
            p = probe_q.pop_front();
            case (p.sel)
                P_RD:    act = bus.RD_DATA;
                P_INTR:  act = {31'd0, intr};
                default: act = {26'd0, active_id};
            endcase
            checks++;
            if (act !== p.exp) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", p.name, act, p.exp);
            end else begin
                $display("ok   %s: 0x%08h", p.name, act);
            end
        end
        if (prev_active == 6'd0 && active_id != 6'd0) begin
            checks++;
            if (exp_id_q.size() == 0) begin
                errors++;
                $display("FAIL svc_id: got %0d expected no service", active_id);
            end else begin
                want = exp_id_q.pop_front();
                if (int'(active_id) != want) begin
                    errors++;
                    $display("FAIL svc_id: got %0d expected %0d", active_id, want);
                end else begin
                    $display("ok   svc_id: %0d", active_id);
                end
            end
        end
        prev_active = active_id;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input probe_e sel, input logic [31:0] exp, input string name);
        probe_t p;
        p.sel  = sel;
        p.exp  = exp;
        p.name = name;
        probe_q.push_back(p);
    endtask

    task automatic bus_wr(input logic [4:0] off, input logic [31:0] d);
        bus.IOBUS_ADDR = BASE + {27'd0, off};
        bus.IOBUS_OUT  = d;
        bus.IOBUS_WR   = 1'b1;
        tick();
        bus.IOBUS_WR   = 1'b0;
        bus.IOBUS_ADDR = '0;
    endtask

    task automatic rd_addr(input logic [31:0] addr, input logic [31:0] exp, input string name);
        bus.IOBUS_ADDR = addr;
        probe(P_RD, exp, name);
        tick();
        bus.IOBUS_ADDR = '0;
    endtask

    task automatic rd(input logic [4:0] off, input logic [31:0] exp, input string name);
        rd_addr(BASE + {27'd0, off}, exp, name);
    endtask

    task automatic sig(input probe_e sel, input logic [31:0] exp, input string name);
        probe(sel, exp, name);
        tick();
    endtask

    task automatic wait_intr(input logic level, input int max_cycles, input string name);
        bit found = 1'b0;
        for (int n = 0; n <= max_cycles; n++) begin
            if (intr === level) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: INTR got %b expected %b within %0d cycles", name, intr, level, max_cycles);
        end else begin
            $display("ok   %s: INTR=%b", name, intr);
        end
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic eoi();
        bus_wr(OFF_EOI, $urandom);
    endtask

    task automatic pulse(input logic [N_CH-1:0] mask);
        irq = irq | mask;
        tick();
        tick();
        tick();
        irq = irq & ~mask;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        logic [31:0] en;
        logic [31:0] burst;
        logic [31:0] served;
        logic [31:0] exp_lat;

        bus.IOBUS_ADDR = '0;
        bus.IOBUS_OUT  = '0;
        bus.IOBUS_WR   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        probe(P_INTR, 0, "rst_intr");
        sig(P_ACT, 0, "rst_active_id");
        rd(OFF_PENDING, 0, "rst_pending");
        rd(OFF_ENABLE, 0, "rst_enable");
        rd(OFF_MODE, 0, "rst_mode");
        rd(OFF_ACTIVE, 0, "rst_active_reg");
        rd(OFF_LATCNT, 0, "rst_latcnt");

        // Register masking and window decode
        bus_wr(OFF_ENABLE, 32'hFFFF_FF5A);
        rd(OFF_ENABLE, 32'h5A, "enable_mask");
        rd_addr(BASE + 32'h24, 0, "outside_window");
        rd_addr(BASE + 32'h18, 0, "unmapped_off");
        bus_wr(OFF_MODE, 32'hFFFF_FFFF);
        rd(OFF_MODE, 32'hFF, "mode_mask");

        // Edge ch2: three-cycle latency, ack clears pending
        bus_wr(OFF_ENABLE, 32'h05);
        bus_wr(OFF_MODE, 32'h05);
        irq = 8'h04;
        sig(P_INTR, 0, "lat_c0");
        sig(P_INTR, 0, "lat_c1");
        sig(P_INTR, 0, "lat_c2");
        sig(P_INTR, 1, "lat_c3");
        irq = 8'h00;
        rd(OFF_PENDING, 32'h04, "pend_before_ack");
        exp_id_q.push_back(3);
        ack();
        rd(OFF_ACTIVE, 3, "active_after_ack");
        rd(OFF_PENDING, 0, "pend_after_ack");
        sig(P_INTR, 0, "intr_in_service");
        ack();
        sig(P_ACT, 3, "ack_in_service_ignored");
        eoi();
        sig(P_ACT, 0, "active_after_eoi");
        sig(P_INTR, 0, "idle_no_req");

        // Simultaneous ch0/ch2: lowest index first
        exp_id_q.push_back(1);
        exp_id_q.push_back(3);
        pulse(8'h05);
        wait_intr(1'b1, 10, "pair_first");
        ack();
        sig(P_ACT, 1, "pair_active1");
        eoi();
        wait_intr(1'b1, 3, "pair_second");
        ack();
        sig(P_ACT, 3, "pair_active3");
        eoi();

        // Level ch1 held high
        bus_wr(OFF_MODE, 32'h00);
        bus_wr(OFF_ENABLE, 32'h02);
        irq = 8'h02;
        exp_id_q.push_back(2);
        wait_intr(1'b1, 10, "lvl_first");
        ack();
        sig(P_ACT, 2, "lvl_active2");
        eoi();
        wait_intr(1'b1, 2, "lvl_reassert");
        bus_wr(OFF_PENDING, 32'h02);
        rd(OFF_PENDING, 32'h02, "lvl_w1c_no_effect");
        irq = 8'h00;
        wait_intr(1'b0, 4, "lvl_drop");
        sig(P_INTR, 0, "lvl_stays_low");
        ack();
        sig(P_ACT, 0, "lvl_no_spurious");
        rd(OFF_PENDING, 0, "lvl_pending_clear");

        // W1C in the same cycle as an edge set: set wins
        bus_wr(OFF_ENABLE, 32'h00);
        bus_wr(OFF_MODE, 32'h04);
        irq = 8'h04;
        tick();
        bus_wr(OFF_PENDING, 32'h04);
        rd(OFF_PENDING, 32'h04, "w1c_vs_set");
        irq = 8'h00;
        bus_wr(OFF_PENDING, 32'h04);
        rd(OFF_PENDING, 0, "w1c_clear");

        // Ack latency counter
`ifdef INTC_LATCNT_EN
        exp_lat = 32'd10;
`else
        exp_lat = 32'd0;
`endif
        bus_wr(OFF_MODE, 32'h01);
        bus_wr(OFF_ENABLE, 32'h01);
        irq = 8'h01;
        exp_id_q.push_back(1);
        wait_intr(1'b1, 10, "latcnt_intr");
        repeat (10) tick();
        ack();
        irq = 8'h00;
        rd(OFF_LATCNT, exp_lat, "latcnt");
        eoi();

        // Reset in the middle of servicing ch2
        bus_wr(OFF_ENABLE, 32'h04);
        bus_wr(OFF_MODE, 32'h04);
        exp_id_q.push_back(3);
        pulse(8'h04);
        wait_intr(1'b1, 10, "svc_before_rst");
        ack();
        sig(P_ACT, 3, "active_before_rst");
        rst = 1'b1;
        probe(P_INTR, 0, "rst_mid_intr");
        sig(P_ACT, 0, "rst_mid_active");
        rst = 1'b0;
        rd(OFF_ENABLE, 0, "rst_mid_enable");
        rd(OFF_ACTIVE, 0, "rst_mid_active_reg");

        // Random bursts against an ascending-index service model
        bus_wr(OFF_MODE, 32'hFF);
        for (int it = 0; it < 12; it++) begin
            en     = 32'($urandom_range(0, 255));
            burst  = 32'($urandom_range(1, 255));
            served = en & burst;
            bus_wr(OFF_ENABLE, en);
            for (int c = 0; c < N_CH; c++) begin
                if (served[c]) exp_id_q.push_back(c + 1);
            end
            pulse(burst[N_CH-1:0]);
            for (int c = 0; c < N_CH; c++) begin
                if (served[c]) begin
                    wait_intr(1'b1, 10, $sformatf("rnd%0d_intr", it));
                    ack();
                    eoi();
                end
            end
            tick();
            probe(P_INTR, 0, $sformatf("rnd%0d_idle", it));
            rd(OFF_PENDING, burst & ~en, $sformatf("rnd%0d_left", it));
            rd(OFF_ACTIVE, 0, $sformatf("rnd%0d_active", it));
            bus_wr(OFF_PENDING, 32'hFF);
            rd(OFF_PENDING, 0, $sformatf("rnd%0d_cleared", it));
        end

        tick();
        checks++;
        if (exp_id_q.size() != 0) begin
            errors++;
            $display("FAIL svc_drain: got %0d unserved expected 0", exp_id_q.size());
        end else begin
            $display("ok   svc_drain: 0");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
